key_press_classifier: RTL and testbench

//  Consumes the debounced press pulse and the raw key level from the key debounce stage.

---
 rtl/key_pkg.sv | 34 +++
 rtl/key_release_filter.sv | 45 ++++
 rtl/key_press_classifier.sv | 160 ++++++++++++++++
 tb/tb_key_press_classifier.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and elaboration helpers for the key press classifier.
// The optional auto-repeat feature is enabled by defining KEY_REPEAT_EN.
package key_pkg;

  // Gesture FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HELD1 = 3'd1,
    LONG  = 3'd2,
    GAP   = 3'd3,
    HELD2 = 3'd4
  } kpc_state_t;

  // Smallest r with 2**r >= v
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter width wide enough for the largest cycle parameter, plus one spare bit
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return clog2_int(m) + 1;
  endfunction

endpackage

// File: rtl/key_release_filter.sv
// Release qualifier: synchronizes the raw active-low key level and asserts
// rel_ok once the key has read released for REL_CYC consecutive cycles.
module key_release_filter
  #(
    parameter int REL_CYC = 1000,
    parameter int CNT_W   = 12
  )
  (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic rel_ok
  );

  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_CYC - 1);

  logic             sync1;
  logic             key_n_s;
  logic [CNT_W-1:0] rel_cnt;

  // Two-flop synchronizer; resets to the released level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      key_n_s <= 1'b1;
    end else begin
      sync1   <= key_n;
      key_n_s <= sync1;
    end
  end

  // Count consecutive released cycles; any pressed sample restarts, count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_cnt <= '0;
    end else if (!key_n_s) begin
      rel_cnt <= '0;
    end else if (rel_cnt != REL_LAST) begin
      rel_cnt <= rel_cnt + CNT_W'(1);
    end
  end

  assign rel_ok = (rel_cnt == REL_LAST);

endmodule

// File: rtl/key_press_classifier.sv
// Key gesture classifier: turns debounced press pulses plus the raw key level
// into one-cycle short / long / double pulses (and optional auto-repeat).
// Define KEY_REPEAT_EN to build the auto-repeat counter; otherwise
// repeat_pulse is tied low.
// Interface: key_press is a single-cycle strobe with no back-pressure; every
// output pulse is a single registered cycle and the consumer must take it then.
module key_press_classifier
  import key_pkg::*;
  #(
    parameter int LONG_CYC    = 2000,
    parameter int DBL_GAP_CYC = 1500,
    parameter int REL_CYC     = 1000,
    parameter int REPEAT_CYC  = 500
  )
  (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic key_press,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic repeat_pulse,
    output logic busy
  );

  localparam int CNT_W = cnt_width(LONG_CYC, DBL_GAP_CYC, REL_CYC, REPEAT_CYC);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);

  kpc_state_t       state;
  kpc_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic             rel_ok;

  logic short_d;
  logic long_d;
  logic double_d;
  logic busy_d;

  key_release_filter #(
    .REL_CYC (REL_CYC),
    .CNT_W   (CNT_W)
  ) u_rel (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .rel_ok (rel_ok)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; release beats the long terminal count, a press beats the gap timeout
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (key_press) next_state = HELD1;
      end
      HELD1: begin
        if (rel_ok)                 next_state = GAP;
        else if (cnt == LONG_LAST)  next_state = LONG;
      end
      LONG: begin
        if (rel_ok) next_state = IDLE;
      end
      GAP: begin
        if (key_press)             next_state = HELD2;
        else if (cnt == GAP_LAST)  next_state = IDLE;
      end
      HELD2: begin
        if (rel_ok) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Shared gesture counter: restarts on every state change, runs only in HELD1 and GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if (state == HELD1 || state == GAP) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Output decode: pulses fire on the transition that classifies the gesture
  always_comb begin
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    busy_d   = (next_state != IDLE);
    case (state)
      HELD1: long_d = !rel_ok && (cnt == LONG_LAST);
      GAP: begin
        double_d = key_press;
        short_d  = !key_press && (cnt == GAP_LAST);
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_pulse  <= short_d;
      long_pulse   <= long_d;
      double_pulse <= double_d;
      busy         <= busy_d;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);

  logic [CNT_W-1:0] rep_cnt;
  logic             repeat_d;

  // Repeat period counter; starts at 0 in the long_pulse cycle and wraps each period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (state != LONG) begin
      rep_cnt <= '0;
    end else if (rep_cnt == REP_LAST) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + CNT_W'(1);
    end
  end

  assign repeat_d = (state == LONG) && !rel_ok && (rep_cnt == REP_LAST);

  // Registered repeat output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= repeat_d;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_press_classifier.sv
// Directed bench for key_press_classifier with small cycle parameters.
// Gesture vectors come from a table; glitch, stray press, reset and
// auto-repeat cases are hand-written sequences.
module tb_key_press_classifier;

  localparam int LONG_CYC    = 20;
  localparam int DBL_GAP_CYC = 15;
  localparam int REL_CYC     = 5;
  localparam int REPEAT_CYC  = 8;

  localparam int K_SHORT  = 0;
  localparam int K_LONG   = 1;
  localparam int K_DOUBLE = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic key_n;
  logic key_press;
  logic short_pulse;
  logic long_pulse;
  logic double_pulse;
  logic repeat_pulse;
  logic busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Pulse monitor: running totals and cycle of the most recent pulse
  int tot_short = 0, tot_long = 0, tot_dbl = 0, tot_rep = 0;
  int t_short = -1, t_long = -1, t_dbl = -1, rep_last = -1, rep_prev = -1;

  key_press_classifier #(
    .LONG_CYC    (LONG_CYC),
    .DBL_GAP_CYC (DBL_GAP_CYC),
    .REL_CYC     (REL_CYC),
    .REPEAT_CYC  (REPEAT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_n        (key_n),
    .key_press    (key_press),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .double_pulse (double_pulse),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  // Clock and cycle counter (cyc = index of the current cycle after each posedge)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (short_pulse)  begin tot_short <= tot_short + 1; t_short <= cyc; end
    if (long_pulse)   begin tot_long  <= tot_long + 1;  t_long  <= cyc; end
    if (double_pulse) begin tot_dbl   <= tot_dbl + 1;   t_dbl   <= cyc; end
    if (repeat_pulse) begin
      tot_rep  <= tot_rep + 1;
      rep_prev <= rep_last;
      rep_last <= cyc;
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lower key_n three cycles ahead (debounce stage lead), then strobe key_press; returns press cycle
  task automatic press(output int p);
    key_n = 1'b0;
    step(); step(); step();
    key_press = 1'b1;
    p = cyc;
    step();
    key_press = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  typedef struct {
    int hold;   // cycles from key_press to key_n release
    int gap;    // re-press cycle offset from rel_ok, -1 for none
    int hold2;  // second hold length
    int kind;   // expected gesture
    int at;     // expected pulse cycle relative to the first key_press
  } gest_t;

  gest_t tbl[8];

  // Timing from press cycle P with release at R = P+hold:
  //   key_n_s rises at R+2, rel_cnt reaches REL_CYC-1 at rel_ok C = R+6.
  //   Short: gap counter hits 14 at C+15, pulse registered at C+16 = P+hold+22.
  //   Long: HELD1 counter hits 19 at P+20, pulse at P+21.
  //   Double: second key_press at C+gap, pulse at C+gap+1.
  initial begin
    tbl[0] = '{hold: 10, gap: -1, hold2: 0, kind: K_SHORT,  at: 32};
    tbl[1] = '{hold:  3, gap: -1, hold2: 0, kind: K_SHORT,  at: 25};
    tbl[2] = '{hold: 30, gap: -1, hold2: 0, kind: K_LONG,   at: 21};
    tbl[3] = '{hold: 14, gap: -1, hold2: 0, kind: K_SHORT,  at: 36}; // rel_ok ties long count
    tbl[4] = '{hold: 15, gap: -1, hold2: 0, kind: K_LONG,   at: 21}; // long one cycle first
    tbl[5] = '{hold: 10, gap:  6, hold2: 4, kind: K_DOUBLE, at: 23};
    tbl[6] = '{hold: 10, gap: 15, hold2: 4, kind: K_DOUBLE, at: 32}; // press ties gap timeout
    tbl[7] = '{hold: 10, gap: 14, hold2: 4, kind: K_DOUBLE, at: 31};
  end

  task automatic run_gesture(input int idx, input gest_t g);
    int s0, l0, d0, p, c;
    string nm;
    s0 = tot_short; l0 = tot_long; d0 = tot_dbl;
    press(p);
    wait_until(p + g.hold);
    key_n = 1'b1;
    if (g.gap >= 0) begin
      c = p + g.hold + 6;
      wait_until(c + g.gap - 3);
      key_n = 1'b0;
      wait_until(c + g.gap);
      key_press = 1'b1;
      step();
      key_press = 1'b0;
      wait_until(c + g.gap + g.hold2);
      key_n = 1'b1;
    end
    repeat (60) step();
    nm = $sformatf("vec%0d", idx);
    check_int({nm, "_short_cnt"},  tot_short - s0, (g.kind == K_SHORT)  ? 1 : 0);
    check_int({nm, "_long_cnt"},   tot_long - l0,  (g.kind == K_LONG)   ? 1 : 0);
    check_int({nm, "_double_cnt"}, tot_dbl - d0,   (g.kind == K_DOUBLE) ? 1 : 0);
    case (g.kind)
      K_SHORT: check_int({nm, "_short_at"},  t_short - p, g.at);
      K_LONG:  check_int({nm, "_long_at"},   t_long - p,  g.at);
      default: check_int({nm, "_double_at"}, t_dbl - p,   g.at);
    endcase
    check_int({nm, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int p, s0, l0, d0, r0;
    rst_n = 1'b0;
    key_n = 1'b1;
    key_press = 1'b0;
    step(); step();
    @(negedge clk);
    check_int("reset_short",  int'(short_pulse),  0);
    check_int("reset_long",   int'(long_pulse),   0);
    check_int("reset_double", int'(double_pulse), 0);
    check_int("reset_repeat", int'(repeat_pulse), 0);
    check_int("reset_busy",   int'(busy),         0);
    step();
    rst_n = 1'b1;
    repeat (10) step();

    for (int i = 0; i < 8; i++) run_gesture(i, tbl[i]);

    // Busy rises one cycle after the press and stays high through HELD1
    press(p);
    check_int("busy_held", int'(busy), 1);
    // Stray key_press while in HELD1 is ignored
    wait_until(p + 5);
    s0 = tot_short; d0 = tot_dbl;
    key_press = 1'b1;
    step();
    key_press = 1'b0;
    wait_until(p + 10);
    key_n = 1'b1;
    repeat (60) step();
    check_int("stray_short_cnt",  tot_short - s0, 1);
    check_int("stray_short_at",   t_short - p,    32);
    check_int("stray_double_cnt", tot_dbl - d0,   0);

    // Release glitch: key_n back to 0 for 2 cycles restarts rel_cnt; rel_ok moves to R+10
    s0 = tot_short;
    press(p);
    wait_until(p + 10);
    key_n = 1'b1;
    step(); step();
    key_n = 1'b0;
    step(); step();
    key_n = 1'b1;
    repeat (60) step();
    check_int("glitch_short_cnt", tot_short - s0, 1);
    check_int("glitch_short_at",  t_short - p,    36);

    // Reset asserted while in GAP aborts the gesture
    s0 = tot_short; l0 = tot_long; d0 = tot_dbl;
    press(p);
    wait_until(p + 10);
    key_n = 1'b1;
    wait_until(p + 20);
    rst_n = 1'b0;
    @(negedge clk);
    check_int("gaprst_busy",   int'(busy),         0);
    check_int("gaprst_short",  int'(short_pulse),  0);
    check_int("gaprst_long",   int'(long_pulse),   0);
    check_int("gaprst_double", int'(double_pulse), 0);
    check_int("gaprst_repeat", int'(repeat_pulse), 0);
    step(); step(); step();
    rst_n = 1'b1;
    repeat (40) step();
    check_int("gaprst_no_short",  tot_short - s0, 0);
    check_int("gaprst_no_long",   tot_long - l0,  0);
    check_int("gaprst_no_double", tot_dbl - d0,   0);
    check_int("gaprst_busy_after", int'(busy),    0);

`ifdef KEY_REPEAT_EN
    // 45-cycle hold: long at P+21, repeats every 8 cycles while LONG and not released
    // (rel_ok at P+51): P+29, P+37, P+45
    s0 = tot_short; l0 = tot_long; r0 = tot_rep;
    press(p);
    wait_until(p + 45);
    key_n = 1'b1;
    repeat (60) step();
    check_int("rep_long_cnt",   tot_long - l0,  1);
    check_int("rep_long_at",    t_long - p,     21);
    check_int("rep_cnt",        tot_rep - r0,   3);
    check_int("rep_prev_at",    rep_prev - p,   37);
    check_int("rep_last_at",    rep_last - p,   45);
    check_int("rep_short_cnt",  tot_short - s0, 0);
`else
    r0 = 0;
    check_int("repeat_never", tot_rep - r0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
